// File: rtl/sparse_pe_pkg.sv
// Shared types, default sizes and arithmetic helpers for the sparse MAC PE.
package sparse_pe_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MERGE,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int unsigned DEF_IA_LEN_MAX = 32;
  localparam int unsigned DEF_W_LEN_MAX  = 64;
  localparam int unsigned DEF_K          = 16;
  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_C_W        = 6;
  localparam int unsigned DEF_ACC_W      = 24;

  // Signed add of two sign-extended operands, clamped to the range of a w-bit
  // signed number (w up to 63). The caller truncates the result back to w bits.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned        w);
    logic signed [64:0] sum;
    logic signed [64:0] maxv;
    logic signed [64:0] minv;
    sum  = 65'(a) + 65'(b);
    maxv = (65'sd1 <<< (w - 1)) - 65'sd1;
    minv = -maxv - 65'sd1;
    if (sum > maxv) begin
      return maxv[63:0];
    end else if (sum < minv) begin
      return minv[63:0];
    end else begin
      return sum[63:0];
    end
  endfunction

endpackage

// File: rtl/sparse_pe_requant.sv
// Requantiser: arithmetic right shift of an accumulator, saturated to DATA_W.
module sparse_pe_requant #(
  parameter int ACC_W  = 24,
  parameter int DATA_W = 8
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic        [4:0]        shift_i,
  output logic        [DATA_W-1:0] data_o
);

  localparam logic signed [ACC_W-1:0] MaxVal = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MinVal = ACC_W'(-(2 ** (DATA_W - 1)));

  logic signed [ACC_W-1:0] shifted;

  assign shifted = acc_i >>> shift_i;

  // Clamp the floored, shifted value into the signed output range.
  always_comb begin
    data_o = shifted[DATA_W-1:0];
    if (shifted > MaxVal) begin
      data_o = MaxVal[DATA_W-1:0];
    end else if (shifted < MinVal) begin
      data_o = MinVal[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/sparse_mac_pe.sv
// Sparse PE: latches compressed IA/weight fibres, merges them on channel index,
// accumulates matching products per kernel and drains requantised results.
module sparse_mac_pe
  import sparse_pe_pkg::*;
#(
  parameter int IA_LEN_MAX = DEF_IA_LEN_MAX,
  parameter int W_LEN_MAX  = DEF_W_LEN_MAX,
  parameter int K          = DEF_K,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int C_W        = DEF_C_W,
  parameter int ACC_W      = DEF_ACC_W
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic                                   i_start,
  input  logic                                   i_acc_clr,
  input  logic [4:0]                             i_shift,
  input  logic [IA_LEN_MAX-1:0][DATA_W-1:0]      i_ia_data,
  input  logic [IA_LEN_MAX-1:0][C_W-1:0]         i_ia_c_idx,
  input  logic [$clog2(IA_LEN_MAX):0]            i_ia_len,
  input  logic [W_LEN_MAX-1:0][DATA_W-1:0]       i_w_data,
  input  logic [W_LEN_MAX-1:0][C_W-1:0]          i_w_c_idx,
  input  logic [W_LEN_MAX-1:0][$clog2(K)-1:0]    i_w_k_idx,
  input  logic [$clog2(W_LEN_MAX):0]             i_w_len,
  input  logic                                   i_out_ready,
  output logic                                   o_busy,
  output logic                                   o_out_valid,
  output logic [DATA_W-1:0]                      o_out_data,
  output logic [$clog2(K)-1:0]                   o_out_k,
  output logic                                   o_finish
);

  localparam int IaAw = $clog2(IA_LEN_MAX);
  localparam int WAw  = $clog2(W_LEN_MAX);
  localparam int IaLw = IaAw + 1;
  localparam int WLw  = WAw + 1;
  localparam int Kw   = $clog2(K);
  localparam int Pw   = 2 * DATA_W;

  state_e                              state_q;
  logic [IA_LEN_MAX-1:0][DATA_W-1:0]   ia_data_q;
  logic [IA_LEN_MAX-1:0][C_W-1:0]      ia_c_q;
  logic [IaLw-1:0]                     ia_len_q;
  logic [W_LEN_MAX-1:0][DATA_W-1:0]    w_data_q;
  logic [W_LEN_MAX-1:0][C_W-1:0]       w_c_q;
  logic [W_LEN_MAX-1:0][Kw-1:0]        w_k_q;
  logic [WLw-1:0]                      w_len_q;
  logic [4:0]                          shift_q;
  logic [IaLw-1:0]                     i_q, i_d;
  logic [WLw-1:0]                      j_q, j_d;
  logic                                p_valid_q;
  logic signed [Pw-1:0]                p_prod_q;
  logic [Kw-1:0]                       p_k_q;
  logic signed [ACC_W-1:0]             acc_q [K];
  logic [Kw-1:0]                       k_q;
  logic                                busy_q;
  logic                                out_valid_q;
  logic [DATA_W-1:0]                   out_data_q;
  logic                                finish_q;

  logic                                start_accept;
  logic                                merge_end;
  logic                                match_step;
  logic [C_W-1:0]                      ia_c_cur;
  logic [C_W-1:0]                      w_c_cur;
  logic [IaLw-1:0]                     ia_len_clamp;
  logic [WLw-1:0]                      w_len_clamp;
  logic [Kw-1:0]                       rq_k;
  logic [DATA_W-1:0]                   rq_data;

  assign start_accept = (state_q == S_IDLE) && i_start;
  assign ia_len_clamp = (i_ia_len > IaLw'(IA_LEN_MAX)) ? IaLw'(IA_LEN_MAX) : i_ia_len;
  assign w_len_clamp  = (i_w_len > WLw'(W_LEN_MAX)) ? WLw'(W_LEN_MAX) : i_w_len;
  assign ia_c_cur     = ia_c_q[i_q[IaAw-1:0]];
  assign w_c_cur      = w_c_q[j_q[WAw-1:0]];
  assign merge_end    = (i_q >= ia_len_q) || (j_q >= w_len_q);
  assign match_step   = (state_q == S_MERGE) && !merge_end && (ia_c_cur == w_c_cur);

  // Two-pointer merge step: smaller channel advances, a match advances the weight side.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (ia_c_cur < w_c_cur) begin
      i_d = i_q + IaLw'(1);
    end else begin
      j_d = j_q + WLw'(1);
    end
  end

  // Drain reads accumulator 0 when entering, then the one after the current beat.
  assign rq_k = (state_q == S_DRAIN) ? k_q + Kw'(1) : '0;

  sparse_pe_requant #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_requant (
    .acc_i   (acc_q[rq_k]),
    .shift_i (shift_q),
    .data_o  (rq_data)
  );

  // Control FSM: operand latching, merge pointers and the registered drain port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      ia_data_q   <= '0;
      ia_c_q      <= '0;
      ia_len_q    <= '0;
      w_data_q    <= '0;
      w_c_q       <= '0;
      w_k_q       <= '0;
      w_len_q     <= '0;
      shift_q     <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            ia_data_q <= i_ia_data;
            ia_c_q    <= i_ia_c_idx;
            ia_len_q  <= ia_len_clamp;
            w_data_q  <= i_w_data;
            w_c_q     <= i_w_c_idx;
            w_k_q     <= i_w_k_idx;
            w_len_q   <= w_len_clamp;
            shift_q   <= i_shift;
            i_q       <= '0;
            j_q       <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_MERGE;
          end
        end
        S_MERGE: begin
          if (merge_end) begin
            state_q <= S_FLUSH;
          end else begin
            i_q <= i_d;
            j_q <= j_d;
          end
        end
        S_FLUSH: begin
          k_q         <= '0;
          out_data_q  <= rq_data;
          out_valid_q <= 1'b1;
          state_q     <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_valid_q && i_out_ready) begin
            if (k_q == Kw'(K - 1)) begin
              out_valid_q <= 1'b0;
              finish_q    <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              k_q        <= k_q + Kw'(1);
              out_data_q <= rq_data;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // MAC stage 1: register the signed product and its kernel for each match.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p_valid_q <= 1'b0;
      p_prod_q  <= '0;
      p_k_q     <= '0;
    end else begin
      p_valid_q <= match_step;
      if (match_step) begin
        p_prod_q <= $signed(ia_data_q[i_q[IaAw-1:0]]) * $signed(w_data_q[j_q[WAw-1:0]]);
        p_k_q    <= w_k_q[j_q[WAw-1:0]];
      end
    end
  end

  // MAC stage 2: clear on an accepted start when asked, else saturating accumulate.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < K; k++) begin
        acc_q[k] <= '0;
      end
    end else if (start_accept && i_acc_clr) begin
      for (int k = 0; k < K; k++) begin
        acc_q[k] <= '0;
      end
    end else if (p_valid_q) begin
      acc_q[p_k_q] <= ACC_W'(sat_add(64'(acc_q[p_k_q]), 64'(p_prod_q), ACC_W));
    end
  end

  assign o_busy      = busy_q;
  assign o_out_valid = out_valid_q;
  assign o_out_data  = out_data_q;
  assign o_out_k     = k_q;
  assign o_finish    = finish_q;

endmodule

// File: tb/tb_sparse_mac_pe.sv
// Self-checking bench for sparse_mac_pe: fixed vectors, hand-written corner
// sequences and randomized fibres against a behavioural model.
module tb_sparse_mac_pe;

  typedef struct packed {
    int stim;
    int a;
    int b;
    int shift;
    bit clr;
    int lat;
    int k0;
    int v0;
    int k1;
    int v1;
  } vec_t;

  logic               clk = 1'b0;
  logic               rstN;
  logic               iStart;
  logic               iAccClr;
  logic [4:0]         iShift;
  logic [31:0][7:0]   iaData;
  logic [31:0][5:0]   iaC;
  logic [5:0]         iaLen;
  logic [63:0][7:0]   wData;
  logic [63:0][5:0]   wC;
  logic [63:0][3:0]   wK;
  logic [6:0]         wLen;
  logic               outReady;
  logic               oBusy;
  logic               oOutValid;
  logic [7:0]         oOutData;
  logic [3:0]         oOutK;
  logic               oFinish;

  int nChecks = 0;
  int nFails  = 0;
  int expOut[16];
  int modelAcc[16];
  vec_t vecs[7];

  always #5 clk = ~clk;

  sparse_mac_pe dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_start     (iStart),
    .i_acc_clr   (iAccClr),
    .i_shift     (iShift),
    .i_ia_data   (iaData),
    .i_ia_c_idx  (iaC),
    .i_ia_len    (iaLen),
    .i_w_data    (wData),
    .i_w_c_idx   (wC),
    .i_w_k_idx   (wK),
    .i_w_len     (wLen),
    .i_out_ready (outReady),
    .o_busy      (oBusy),
    .o_out_valid (oOutValid),
    .o_out_data  (oOutData),
    .o_out_k     (oOutK),
    .o_finish    (oFinish)
  );

  // Compare one observed value against the bench's own expectation.
  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int sat(input longint v, input int w);
    longint mx;
    longint mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    if (v > mx) return int'(mx);
    if (v < mn) return int'(mn);
    return int'(v);
  endfunction

  // Fill every slot with junk so entries beyond the lengths are exercised as don't-cares.
  task automatic fillGarbage();
    for (int i = 0; i < 32; i++) begin
      iaData[i] = 8'($urandom);
      iaC[i]    = 6'($urandom);
    end
    for (int j = 0; j < 64; j++) begin
      wData[j] = 8'($urandom);
      wC[j]    = 6'($urandom);
      wK[j]    = 4'($urandom);
    end
  endtask

  // stim 0: basic fibres, 1: single product a*b on kernel 3, 2: basic weights with empty IA.
  task automatic loadStim(input int stim, input int a, input int b);
    fillGarbage();
    if (stim == 1) begin
      iaLen = 6'd1; iaC[0] = 6'd0; iaData[0] = 8'(a);
      wLen = 7'd1; wC[0] = 6'd0; wK[0] = 4'd3; wData[0] = 8'(b);
    end else begin
      iaLen = 6'd2;
      iaC[0] = 6'd1; iaData[0] = 8'(3);
      iaC[1] = 6'd4; iaData[1] = 8'(-2);
      wLen = 7'd4;
      wC[0] = 6'd1; wK[0] = 4'd0; wData[0] = 8'(5);
      wC[1] = 6'd1; wK[1] = 4'd2; wData[1] = 8'(2);
      wC[2] = 6'd4; wK[2] = 4'd0; wData[2] = 8'(7);
      wC[3] = 6'd5; wK[3] = 4'd1; wData[3] = 8'(9);
      if (stim == 2) iaLen = 6'd0;
    end
  endtask

  task automatic setExpected(input int k0, input int v0, input int k1, input int v1);
    for (int k = 0; k < 16; k++) expOut[k] = 0;
    expOut[k0] = v0;
    expOut[k1] = v1;
  endtask

  // Pulse start for one cycle, then wait for the first output beat and check its latency.
  task automatic applyStimulus(input bit clr, input int shift, input int expLat, input string tag);
    int lat;
    @(negedge clk);
    iStart = 1'b1; iAccClr = clr; iShift = 5'(shift); outReady = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    checkOutput({tag, " busy after start"}, int'(oBusy), 1);
    lat = 1;
    while (!oOutValid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!oOutValid) checkOutput({tag, " valid timeout"}, 0, 1);
    else if (expLat >= 0) checkOutput({tag, " first valid latency"}, lat, expLat);
  endtask

  // Consume all K beats, optionally stalling 3 cycles at one beat and pulsing start mid-drain.
  task automatic drainAndCheck(input string tag, input int stallAt, input int pulseAt);
    int beat, cyc, stall, heldD, heldK;
    beat = 0; cyc = 0; stall = 0; heldD = 0; heldK = 0;
    while (beat < 16 && cyc < 400) begin
      if (cyc == pulseAt) begin
        iStart = 1'b1; iAccClr = 1'b1;
      end else begin
        iStart = 1'b0;
      end
      if (beat == stallAt && stall < 3) begin
        outReady = 1'b0;
        if (stall == 0) begin
          heldD = int'($signed(oOutData)); heldK = int'(oOutK);
        end else begin
          checkOutput({tag, " held data"}, int'($signed(oOutData)), heldD);
          checkOutput({tag, " held k"}, int'(oOutK), heldK);
        end
        stall++;
      end else begin
        outReady = 1'b1;
        checkOutput({tag, " valid"}, int'(oOutValid), 1);
        checkOutput($sformatf("%s k beat%0d", tag, beat), int'(oOutK), beat);
        checkOutput($sformatf("%s data k%0d", tag, beat), int'($signed(oOutData)), expOut[beat]);
        beat++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    iStart = 1'b0;
    outReady = 1'b1;
    if (beat < 16) checkOutput({tag, " drain timeout"}, beat, 16);
    checkOutput({tag, " finish pulse"}, int'(oFinish), 1);
    checkOutput({tag, " valid after last"}, int'(oOutValid), 0);
    @(posedge clk); #1;
    checkOutput({tag, " finish drop"}, int'(oFinish), 0);
    checkOutput({tag, " idle busy"}, int'(oBusy), 0);
  endtask

  // Random fibres checked against a pairwise-match reference accumulated in weight order.
  task automatic runRandom(input int r);
    int chans[$];
    int wch[$];
    int iv[32];
    int wv[64];
    int wk[64];
    int iaN, wN, shift;
    bit clr;
    string tag;
    tag = $sformatf("rand%0d", r);
    chans.delete();
    wch.delete();
    for (int c = 0; c < 64; c++) begin
      if ((r == 2) ? (c < 32) : ($urandom_range(1, 0) == 1)) chans.push_back(c);
    end
    while (chans.size() > 32) void'(chans.pop_back());
    iaN = chans.size();
    wN  = (r == 5) ? 64 : int'($urandom_range(64, 0));
    for (int n = 0; n < wN; n++) wch.push_back(int'($urandom_range(63, 0)));
    wch.sort();
    fillGarbage();
    for (int i = 0; i < iaN; i++) begin
      iv[i] = int'($urandom_range(255, 0)) - 128;
      iaC[i] = 6'(chans[i]);
      iaData[i] = 8'(iv[i]);
    end
    for (int j = 0; j < wN; j++) begin
      wv[j] = int'($urandom_range(255, 0)) - 128;
      wk[j] = int'($urandom_range(15, 0));
      wC[j] = 6'(wch[j]);
      wK[j] = 4'(wk[j]);
      wData[j] = 8'(wv[j]);
    end
    iaLen = (r == 2) ? 6'd40 : 6'(iaN);
    wLen  = (r == 5) ? 7'd100 : 7'(wN);
    shift = int'($urandom_range(12, 0));
    clr   = (r == 0) || ($urandom_range(1, 0) == 1);
    if (clr) for (int k = 0; k < 16; k++) modelAcc[k] = 0;
    for (int j = 0; j < wN; j++) begin
      for (int i = 0; i < iaN; i++) begin
        if (chans[i] == wch[j]) modelAcc[wk[j]] = sat(longint'(modelAcc[wk[j]]) + longint'(iv[i] * wv[j]), 24);
      end
    end
    for (int k = 0; k < 16; k++) expOut[k] = sat(longint'(modelAcc[k] >>> shift), 8);
    applyStimulus(clr, shift, -1, tag);
    drainAndCheck(tag, -1, -1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rstN = 1'b0; iStart = 1'b0; iAccClr = 1'b0; iShift = 5'd0; outReady = 1'b1;
    iaData = '0; iaC = '0; iaLen = '0; wData = '0; wC = '0; wK = '0; wLen = '0;
    #12;
    checkOutput("reset busy", int'(oBusy), 0);
    checkOutput("reset valid", int'(oOutValid), 0);
    checkOutput("reset data", int'(oOutData), 0);
    checkOutput("reset k", int'(oOutK), 0);
    checkOutput("reset finish", int'(oFinish), 0);
    @(negedge clk);
    rstN = 1'b1;

    vecs[0] = '{0, 0, 0, 0, 1'b1, 8, 0, 1, 2, 6};
    vecs[1] = '{0, 0, 0, 0, 1'b0, 8, 0, 2, 2, 12};
    vecs[2] = '{1, 127, 127, 0, 1'b1, 4, 3, 127, 3, 127};
    vecs[3] = '{1, 127, 127, 7, 1'b1, 4, 3, 126, 3, 126};
    vecs[4] = '{1, -128, 127, 0, 1'b1, 4, 3, -128, 3, -128};
    vecs[5] = '{1, -3, 5, 2, 1'b1, 4, 3, -4, 3, -4};
    vecs[6] = '{2, 0, 0, 0, 1'b1, 3, 0, 0, 0, 0};
    for (int v = 0; v < 7; v++) begin
      loadStim(vecs[v].stim, vecs[v].a, vecs[v].b);
      setExpected(vecs[v].k0, vecs[v].v0, vecs[v].k1, vecs[v].v1);
      applyStimulus(vecs[v].clr, vecs[v].shift, vecs[v].lat, $sformatf("vec%0d", v));
      drainAndCheck($sformatf("vec%0d", v), -1, -1);
    end

    loadStim(0, 0, 0);
    setExpected(0, 1, 2, 6);
    applyStimulus(1'b1, 0, 8, "stall");
    drainAndCheck("stall", 5, 7);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ignored start busy", int'(oBusy), 0);
    setExpected(0, 2, 2, 12);
    applyStimulus(1'b0, 0, 8, "after stall");
    drainAndCheck("after stall", -1, -1);

    loadStim(0, 0, 0);
    @(negedge clk);
    iStart = 1'b1; iAccClr = 1'b0; iShift = 5'd0;
    @(posedge clk); #1;
    iStart = 1'b0;
    @(posedge clk); #1;
    checkOutput("pre-reset busy", int'(oBusy), 1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midrst busy", int'(oBusy), 0);
    checkOutput("midrst valid", int'(oOutValid), 0);
    checkOutput("midrst data", int'(oOutData), 0);
    checkOutput("midrst k", int'(oOutK), 0);
    checkOutput("midrst finish", int'(oFinish), 0);
    @(negedge clk);
    rstN = 1'b1;
    setExpected(0, 1, 2, 6);
    applyStimulus(1'b0, 0, 8, "post reset");
    drainAndCheck("post reset", -1, -1);

    for (int r = 0; r < 10; r++) runRandom(r);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/sparse_mac_pe.md
# sparse_mac_pe

Parametrised sparse processing element for the object-tracking CNN accelerator. It latches one compressed input-activation fibre (nonzero values with channel indices) and one compressed weight fibre (nonzero values with channel and kernel indices). It intersects the two on channel index with a two-pointer merge and multiply-accumulates the matches into K output accumulators. It then streams requantised, saturated results out over a valid/ready port. Accumulators can persist across starts, which allows multi-pass channel tiling.

## Interface
- `IA_LEN_MAX`, default 32: maximum nonzero IA entries per fibre.
- `W_LEN_MAX`, default 64: maximum nonzero weight entries per fibre.
- `K`, default 16: number of output kernels (accumulators).
- `DATA_W`, default 8: signed IA, weight and output data width.
- `C_W`, default 6: channel index width.
- `ACC_W`, default 24: signed accumulator width.
- `i_clk` in 1: clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_start` in 1: start pulse. Accepted only in S_IDLE; ignored otherwise.
- `i_acc_clr` in 1: sampled with `i_start`. When 1, all accumulators clear before the merge.
- `i_shift` in 5: arithmetic right shift applied at requantisation. Sampled with `i_start`.
- `i_ia_data` in DATA_W x IA_LEN_MAX: IA values.
- `i_ia_c_idx` in C_W x IA_LEN_MAX: IA channels. Must be strictly ascending.
- `i_ia_len` in clog2(IA_LEN_MAX)+1: valid IA entries.
- `i_w_data` in DATA_W x W_LEN_MAX: weight values.
- `i_w_c_idx` in C_W x W_LEN_MAX: weight channels. Must be non-decreasing.
- `i_w_k_idx` in clog2(K) x W_LEN_MAX: weight kernel index.
- `i_w_len` in clog2(W_LEN_MAX)+1: valid weight entries.
- `i_out_ready` in 1: downstream ready.
- `o_busy` out 1: high whenever the state is not S_IDLE.
- `o_out_valid` out 1: output beat valid.
- `o_out_data` out DATA_W: requantised result.
- `o_out_k` out clog2(K): kernel index of the current beat.
- `o_finish` out 1: one-cycle pulse after the last beat.

## Operation
- States and transitions: S_IDLE -> S_MERGE -> S_FLUSH -> S_DRAIN -> S_DONE -> S_IDLE.
- Input latching: all input arrays, lengths, `i_shift` and `i_acc_clr` are registered on the accepted start cycle.
- Length clamping: lengths above their max are clamped to the max.
- Clear on start: if the clear flag is set, the accumulators clear on that same cycle.
- S_MERGE, per cycle, with pointers i (IA) and j (weight) both starting at 0:
  - If i ≥ ia_len or j ≥ w_len: go to S_FLUSH. No step is taken.
  - Else if ia_c[i] < w_c[j]: i++.
  - Else if ia_c[i] > w_c[j]: j++.
  - Else (match): issue product ia_data[i]·w_data[j] for kernel w_k[j], then j++.
- MAC pipeline:
  - Stage 1 registers the 2·DATA_W signed product and its k.
  - Stage 2 performs acc[k] += product with saturating add at ACC_W.
  - Back-to-back products to the same k accumulate correctly. Stage 2 is a single-cycle read-modify-write, so no hazard exists.
- S_FLUSH: one cycle that retires the last product.
- S_DRAIN:
  - Beats are emitted for k = 0..K-1 in order.
  - `o_out_data` = sat_DATA_W(acc[k] >>> shift). The shift is arithmetic, so it floors.
  - A beat advances only on valid && ready.
  - Data and k are held stable while ready is low.
- S_DONE: `o_finish` = 1 for one cycle, then return to S_IDLE.
- Accumulators are otherwise retained between runs.
- Unsorted index inputs give undefined sums. The block still terminates within ia_len + w_len steps.

## Timing
- Reset values:
  - State returns to S_IDLE.
  - i, j and all accumulators are 0.
  - `o_busy`, `o_out_valid`, `o_out_data`, `o_out_k` and `o_finish` are all 0.
- Start cycle T: `o_busy` goes high at T+1.
- Merge length: with S merge steps, S_MERGE occupies T+1..T+S+1 and S_FLUSH is at T+S+2.
- First drain beat: `o_out_valid` first rises at T+S+3.
- Bound on S: S ≤ ia_len + w_len. Zero-length input gives S = 0.
- Full-throughput drain: with ready held high, the drain takes K cycles. `o_finish` then pulses the cycle after the last handshake.
- Simultaneous events: a start while busy is ignored and does not affect the run in progress.
- Reset mid-operation: asynchronous return to the reset values. Accumulators clear, and no `o_finish` is emitted.

## Structure
- Package `sparse_pe_pkg`: the state enum (S_IDLE, S_MERGE, S_FLUSH, S_DRAIN, S_DONE), default parameter constants, and a saturating-add function.
- Sub-module `sparse_pe_requant`: combinational arithmetic shift plus saturation from ACC_W to DATA_W. It is instantiated once on the drain path.

## Test plan
- Basic match (K=16, shift 0, clear set):
  - Stimulus: IA {(c1,3),(c4,-2)}. Weights {(c1,k0,5),(c1,k2,2),(c4,k0,7),(c5,k1,9)}.
  - Response: k0 = 1, k2 = 6, all other k = 0. S = 5, so the first valid is at T+8.
- Multi-pass accumulation: repeat the basic-match stimulus with the clear flag off -> k0 = 2, k2 = 12.
- Saturation and shift:
  - 127·127 with shift 0 -> 127.
  - 127·127 with shift 7 -> 126.
  - -128·127 with shift 0 -> -128.
- Empty input: ia_len = 0 -> all K beats are 0. The first valid is at T+3.
- Backpressure and ignored start:
  - Stimulus: hold ready low for 3 cycles mid-drain, and pulse start during the drain.
  - Response: the beat and `o_out_k` stay stable, no beat is lost, and the extra start has no effect.
- Reset mid-merge:
  - Stimulus: assert reset during S_MERGE, then run the basic-match stimulus with the clear flag off.
  - Response: outputs go to their reset values immediately. The next run gives the single-pass result (k0 = 1, k2 = 6).
